beta_pipe_ctrl: RTL and testbench

- Global Pipeline Control Unit for the 5-stage core.
- Drives stall/flush of every pipeline register (IF/DEC, DEC/EXE, EXE/MEM, MEM/WB) and the PC register.
- Inputs are hazard and status indications from decode, execute and memory.
- Adds a small post-redirect FSM (discards stale in-flight fetches) and a stall-cycle performance counter.

---
 rtl/beta_pipe_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_beta_pipe_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/beta_pipe_ctrl.sv
// Global pipeline control for the 5-stage core: prioritised stall/flush generation,
// post-redirect fetch-discard FSM and a stall-cycle performance counter.
module beta_pipe_ctrl #(
  parameter int unsigned RedirectBubbles = 1,
  parameter int unsigned CntWidth        = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [4:0]          dec_rs1_addr_i,
  input  logic [4:0]          dec_rs2_addr_i,
  input  logic                dec_rs1_used_i,
  input  logic                dec_rs2_used_i,
  input  logic                exe_is_load_i,
  input  logic [4:0]          exe_rd_addr_i,
  input  logic                exe_busy_i,
  input  logic                exe_branch_taken_i,
  input  logic                trap_i,
  input  logic                imem_ready_i,
  input  logic                dmem_req_i,
  input  logic                dmem_ready_i,
  input  logic                perf_clr_i,
  output logic                pc_stall_o,
  output logic                if_dec_stall_o,
  output logic                if_dec_flush_o,
  output logic                dec_exe_stall_o,
  output logic                dec_exe_flush_o,
  output logic                exe_mem_stall_o,
  output logic                exe_mem_flush_o,
  output logic                mem_wb_stall_o,
  output logic                mem_wb_flush_o,
  output logic [CntWidth-1:0] stall_cnt_o
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  localparam logic [3:0]          LP_BUBBLES = 4'(RedirectBubbles);
  localparam logic [CntWidth-1:0] LP_CNT_ONE = {{(CntWidth-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_bubble;
  logic [3:0]          w_bubble_nxt;
  logic [CntWidth-1:0] r_stall_cnt;

  logic w_mem_wait;
  logic w_load_use;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_redirect_take;

  logic w_pc_stall;
  logic w_if_dec_stall;
  logic w_if_dec_flush;
  logic w_dec_exe_stall;
  logic w_dec_exe_flush;
  logic w_exe_mem_stall;
  logic w_exe_mem_flush;
  logic w_mem_wb_stall;
  logic w_mem_wb_flush;

  // Hazard detection terms; x0 is never a real producer so it cannot cause load-use.
  always_comb begin
    w_mem_wait = dmem_req_i & ~dmem_ready_i;
    w_rs1_hit  = dec_rs1_used_i & (dec_rs1_addr_i == exe_rd_addr_i);
    w_rs2_hit  = dec_rs2_used_i & (dec_rs2_addr_i == exe_rd_addr_i);
    w_load_use = exe_is_load_i & (exe_rd_addr_i != 5'd0) & (w_rs1_hit | w_rs2_hit);
  end

  // Priority-ordered hazard resolution; only the highest active hazard drives controls.
  always_comb begin
    w_pc_stall      = 1'b0;
    w_if_dec_stall  = 1'b0;
    w_if_dec_flush  = 1'b0;
    w_dec_exe_stall = 1'b0;
    w_dec_exe_flush = 1'b0;
    w_exe_mem_stall = 1'b0;
    w_exe_mem_flush = 1'b0;
    w_mem_wb_stall  = 1'b0;
    w_mem_wb_flush  = 1'b0;
    w_redirect_take = 1'b0;
    if (trap_i) begin
      w_if_dec_flush  = 1'b1;
      w_dec_exe_flush = 1'b1;
      w_exe_mem_flush = 1'b1;
      w_mem_wb_flush  = 1'b1;
      w_redirect_take = 1'b1;
    end else if (w_mem_wait) begin
      // EXE is frozen here, so a taken branch stays presented until memory completes.
      w_pc_stall      = 1'b1;
      w_if_dec_stall  = 1'b1;
      w_dec_exe_stall = 1'b1;
      w_exe_mem_stall = 1'b1;
      w_mem_wb_flush  = 1'b1;
    end else if (exe_busy_i) begin
      w_pc_stall      = 1'b1;
      w_if_dec_stall  = 1'b1;
      w_dec_exe_stall = 1'b1;
      w_exe_mem_flush = 1'b1;
    end else if (exe_branch_taken_i) begin
      w_if_dec_flush  = 1'b1;
      w_dec_exe_flush = 1'b1;
      w_redirect_take = 1'b1;
    end else if (w_load_use) begin
      w_pc_stall      = 1'b1;
      w_if_dec_stall  = 1'b1;
      w_dec_exe_flush = 1'b1;
    end else if (!imem_ready_i) begin
      w_pc_stall      = 1'b1;
      w_if_dec_flush  = 1'b1;
    end else begin
      w_pc_stall      = 1'b0;
    end
  end

  // Output drive: reset forces every register flushed; REDIRECT keeps discarding fetches.
  always_comb begin
    if (rst_i) begin
      pc_stall_o      = 1'b0;
      if_dec_stall_o  = 1'b0;
      if_dec_flush_o  = 1'b1;
      dec_exe_stall_o = 1'b0;
      dec_exe_flush_o = 1'b1;
      exe_mem_stall_o = 1'b0;
      exe_mem_flush_o = 1'b1;
      mem_wb_stall_o  = 1'b0;
      mem_wb_flush_o  = 1'b1;
    end else begin
      pc_stall_o      = w_pc_stall;
      if_dec_stall_o  = w_if_dec_stall;
      if_dec_flush_o  = w_if_dec_flush | (r_state == ST_REDIRECT);
      dec_exe_stall_o = w_dec_exe_stall;
      dec_exe_flush_o = w_dec_exe_flush;
      exe_mem_stall_o = w_exe_mem_stall;
      exe_mem_flush_o = w_exe_mem_flush;
      mem_wb_stall_o  = w_mem_wb_stall;
      mem_wb_flush_o  = w_mem_wb_flush;
    end
  end

  // Redirect FSM next state; bubbles only retire on cycles the front end actually advances.
  always_comb begin
    w_state_nxt  = r_state;
    w_bubble_nxt = r_bubble;
    case (r_state)
      ST_RUN: begin
        if (w_redirect_take) begin
          w_state_nxt  = ST_REDIRECT;
          w_bubble_nxt = LP_BUBBLES;
        end else begin
          w_state_nxt  = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        if (w_redirect_take) begin
          w_state_nxt  = ST_REDIRECT;
          w_bubble_nxt = LP_BUBBLES;
        end else if (!w_pc_stall && !w_mem_wait) begin
          if (r_bubble <= 4'd1) begin
            w_state_nxt  = ST_RUN;
            w_bubble_nxt = 4'd0;
          end else begin
            w_bubble_nxt = r_bubble - 4'd1;
          end
        end else begin
          w_state_nxt  = ST_REDIRECT;
        end
      end
      default: begin
        w_state_nxt  = ST_RUN;
        w_bubble_nxt = 4'd0;
      end
    endcase
  end

  // Redirect FSM state and bubble counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_RUN;
      r_bubble <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_bubble <= w_bubble_nxt;
    end
  end

  // Stall-cycle performance counter; clear wins over increment, wraps naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (perf_clr_i) begin
      r_stall_cnt <= '0;
    end else if (w_pc_stall) begin
      r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_beta_pipe_ctrl.sv
// Directed bench for beta_pipe_ctrl (RedirectBubbles=1, CntWidth=4).
module tb_beta_pipe_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [4:0]    rs1, rs2, rd;
  logic          rs1_used, rs2_used, is_load, busy, br, trap, imem_rdy, dreq, drdy, pclr;
  logic          pc_stall, ifd_s, ifd_f, dex_s, dex_f, emm_s, emm_f, mwb_s, mwb_f;
  logic [CW-1:0] cnt;

  int n_checks = 0;
  int n_err    = 0;

  // Vector order: pc, if_dec S/F, dec_exe S/F, exe_mem S/F, mem_wb S/F
  localparam logic [8:0] V_IDLE  = 9'b000000000;
  localparam logic [8:0] V_RST   = 9'b001010101;
  localparam logic [8:0] V_LU    = 9'b110010000;
  localparam logic [8:0] V_BR    = 9'b001010000;
  localparam logic [8:0] V_REDIR = 9'b001000000;
  localparam logic [8:0] V_MEMW  = 9'b110101001;
  localparam logic [8:0] V_BUSY  = 9'b110100100;
  localparam logic [8:0] V_IMEM  = 9'b101000000;

  beta_pipe_ctrl #(.RedirectBubbles(1), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .dec_rs1_addr_i(rs1), .dec_rs2_addr_i(rs2),
    .dec_rs1_used_i(rs1_used), .dec_rs2_used_i(rs2_used),
    .exe_is_load_i(is_load), .exe_rd_addr_i(rd), .exe_busy_i(busy),
    .exe_branch_taken_i(br), .trap_i(trap), .imem_ready_i(imem_rdy),
    .dmem_req_i(dreq), .dmem_ready_i(drdy), .perf_clr_i(pclr),
    .pc_stall_o(pc_stall), .if_dec_stall_o(ifd_s), .if_dec_flush_o(ifd_f),
    .dec_exe_stall_o(dex_s), .dec_exe_flush_o(dex_f),
    .exe_mem_stall_o(emm_s), .exe_mem_flush_o(emm_f),
    .mem_wb_stall_o(mwb_s), .mem_wb_flush_o(mwb_f),
    .stall_cnt_o(cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_o(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {pc_stall, ifd_s, ifd_f, dex_s, dex_f, emm_s, emm_f, mwb_s, mwb_f};
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: outputs observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input logic [CW-1:0] exp);
    n_checks++;
    assert (cnt === exp) else begin
      n_err++;
      $error("FAIL %s: stall_cnt observed=%0d expected=%0d", tag, cnt, exp);
    end
  endtask

  task automatic idle();
    rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
    rs1_used = 1'b0; rs2_used = 1'b0; is_load = 1'b0; busy = 1'b0; br = 1'b0;
    trap = 1'b0; imem_rdy = 1'b1; dreq = 1'b0; drdy = 1'b0; pclr = 1'b0;
  endtask

  // Advance to the next falling edge with idle inputs applied.
  task automatic step_idle();
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    chk_o("reset_outputs", V_RST);
    chk_c("reset_cnt", 4'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk_o("idle_after_reset", V_IDLE);
    chk_c("idle_cnt", 4'd0);

    // load-use through rs2
    step_idle();
    is_load = 1'b1; rd = 5'd5; rs2 = 5'd5; rs2_used = 1'b1;
    #1 chk_o("load_use_rs2", V_LU);
    // same pattern with rd=x0: no hazard
    step_idle();
    is_load = 1'b1; rd = 5'd0; rs2 = 5'd0; rs2_used = 1'b1;
    #1 chk_o("load_use_x0", V_IDLE);
    chk_c("cnt_after_load_use", 4'd1);
    // load-use through rs1, rs1_used=0 must not trigger
    step_idle();
    is_load = 1'b1; rd = 5'd7; rs1 = 5'd7; rs1_used = 1'b0;
    #1 chk_o("load_use_unused_rs1", V_IDLE);

    // branch redirect with one bubble
    step_idle();
    br = 1'b1;
    #1 chk_o("branch_c0", V_BR);
    step_idle();
    #1 chk_o("branch_c1", V_REDIR);
    step_idle();
    #1 chk_o("branch_c2", V_IDLE);
    chk_c("cnt_after_branch", 4'd1);

    // memory wait masking a taken branch for three cycles
    step_idle();
    pclr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_idle();
      dreq = 1'b1; drdy = 1'b0; br = 1'b1;
      #1 chk_o($sformatf("mem_wait_%0d", i), V_MEMW);
      if (i == 0) chk_c("cnt_cleared", 4'd0);
    end
    step_idle();
    dreq = 1'b1; drdy = 1'b1; br = 1'b1;
    #1 chk_o("mem_done_branch", V_BR);
    chk_c("cnt_after_mem_wait", 4'd3);
    step_idle();
    #1 chk_o("mem_branch_redirect", V_REDIR);
    step_idle();
    #1 chk_o("mem_branch_run", V_IDLE);

    // trap beats load-use and busy
    step_idle();
    trap = 1'b1; busy = 1'b1; is_load = 1'b1; rd = 5'd4; rs1 = 5'd4; rs1_used = 1'b1;
    #1 chk_o("trap_priority", V_RST);
    step_idle();
    #1 chk_o("trap_redirect", V_REDIR);
    step_idle();
    #1 chk_o("trap_run", V_IDLE);
    chk_c("cnt_after_trap", 4'd3);

    // multicycle EXE busy
    step_idle();
    busy = 1'b1;
    #1 chk_o("exe_busy", V_BUSY);
    step_idle();
    #1 chk_c("cnt_after_busy", 4'd4);

    // redirect bubble held while fetch stalls
    step_idle();
    br = 1'b1;
    step_idle();
    imem_rdy = 1'b0;
    #1 chk_o("redirect_imem_stall", V_IMEM);
    step_idle();
    #1 chk_o("redirect_still_held", V_REDIR);
    step_idle();
    #1 chk_o("redirect_release", V_IDLE);

    // counter wrap: clear, then 16 stall cycles
    step_idle();
    pclr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step_idle();
      imem_rdy = 1'b0;
      if (i == 0) begin
        #1 chk_o("imem_not_ready", V_IMEM);
      end
      if (i == 15) begin
        #1 chk_c("cnt_all_ones", 4'd15);
      end
    end
    step_idle();
    #1 chk_c("cnt_wrap", 4'd0);
    // clear during a stall cycle wins over increment
    step_idle();
    imem_rdy = 1'b0;
    step_idle();
    imem_rdy = 1'b0; pclr = 1'b1;
    #1 chk_c("cnt_before_clr", 4'd1);
    step_idle();
    #1 chk_c("cnt_clr_priority", 4'd0);

    // asynchronous reset mid-REDIRECT
    step_idle();
    br = 1'b1;
    @(posedge clk);
    #2;
    idle();
    rst = 1'b1;
    #1 chk_o("async_reset_outputs", V_RST);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_o("reset_left_redirect", V_IDLE);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
